i2c_slave_rx_word: RTL and testbench

- Parametrised I2C slave receive front end: deserialises words of 1..DATA_WIDTH bits, MSB first, from the bus.
- Adds what the single-bit/byte reader lacked: input synchroniser, glitch filter, internal shift register, parallel word output, runtime word length and error abort.
- Sits between the bus pads and the slave protocol FSM, which drives rd_en/rd_len and consumes data_o/data_valid.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_line_filter.sv | 54 +++++
 rtl/i2c_slave_rx_word.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_slave_rx_word.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C word receiver: receive-state encoding and
// the width helper for the bit counter / word-length port.
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } rx_state_e;

   // Bits needed to count 0..dw inclusive (CNT_W of the receiver).
   function automatic int cnt_width(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: metastability synchroniser followed by a glitch filter.
// The filtered output only follows the synchronised input after FILTER_LEN
// consecutive samples disagree with it. Everything resets to the idle-bus
// level (1).
module i2c_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic line_o
);

   localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [FCNT_W-1:0] RELOAD = FCNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   samp;
   logic                   filt_q, filt_d;
   logic [FCNT_W-1:0]      cnt_q, cnt_d;

   assign samp   = sync_q[SYNC_STAGES-1];
   assign line_o = filt_q;

   // Down-counter armed with FILTER_LEN-1; a disagreeing sample at terminal
   // count flips the output, any agreeing sample re-arms it.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      if (samp == filt_q) begin
         cnt_d = RELOAD;
      end else if (cnt_q == '0) begin
         filt_d = samp;
         cnt_d  = RELOAD;
      end else begin
         cnt_d = cnt_q - FCNT_W'(1);
      end
   end

   // Synchroniser chain and filter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         filt_q <= 1'b1;
         cnt_q  <= RELOAD;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/i2c_slave_rx_word.sv
// I2C slave receive front end: filters SCL/SDA, detects START/STOP, and
// deserialises MSB-first words of a runtime-selected length into data_o.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | rd_en low; framing cleared, pulses suppressed, data_o held
// ST_ARMED | waiting for the first bit of a word (bit_cnt = 0)
// ST_SHIFT | word partially received (rd_busy)
// ST_DONE  | one cycle: publish masked word, pulse data_valid
module i2c_slave_rx_word
   import i2c_pkg::*;
#(
   parameter int  DATA_WIDTH  = 8,
   parameter int  SYNC_STAGES = 2,
   parameter int  FILTER_LEN  = 3,
   localparam int CNT_W       = cnt_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [CNT_W-1:0]      rd_len,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  data_valid,
   output logic                  bit_ld,
   output logic                  rd_busy,
   output logic                  get_start,
   output logic                  get_stop,
   output logic                  rd_err,
   input  logic                  scl_i,
   input  logic                  sda_i
);

   localparam logic [CNT_W-1:0] DW_CNT = CNT_W'(DATA_WIDTH);

   logic scl_f, sda_f;
   logic scl_prev_q, sda_prev_q;
   logic scl_rise, scl_fall, sda_rise, sda_fall;
   logic cond_start, cond_stop;

   rx_state_e             state_q, state_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]      bit_cnt_inc;
   logic [CNT_W-1:0]      len_eff;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] shreg_shift;
   logic [DATA_WIDTH-1:0] len_mask;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  smp_q, smp_d;
   logic                  smp_vld_q, smp_vld_d;
   logic                  valid_q, valid_d;
   logic                  bit_ld_q, bit_ld_d;
   logic                  start_q, start_d;
   logic                  stop_q, stop_d;
   logic                  err_q, err_d;

   i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_scl_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (scl_i),
      .line_o (scl_f)
   );

   i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sda_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (sda_i),
      .line_o (sda_f)
   );

   assign scl_rise = scl_f & ~scl_prev_q;
   assign scl_fall = ~scl_f & scl_prev_q;
   assign sda_rise = sda_f & ~sda_prev_q;
   assign sda_fall = ~sda_f & sda_prev_q;

   // SCL must have been high on both sides of the SDA edge; an SDA edge that
   // coincides with scl_fall is a normal data change, not a bus condition.
   assign cond_start = scl_f & scl_prev_q & sda_fall;
   assign cond_stop  = scl_f & scl_prev_q & sda_rise;

   assign len_eff     = ((rd_len == '0) || (rd_len > DW_CNT)) ? DW_CNT : rd_len;
   assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);
   assign shreg_shift = (shreg_q << 1) | DATA_WIDTH'(smp_q);

   assign data_o     = data_q;
   assign data_valid = valid_q;
   assign bit_ld     = bit_ld_q;
   assign rd_busy    = (state_q == ST_SHIFT);
   assign get_start  = start_q;
   assign get_stop   = stop_q;
   assign rd_err     = err_q;

   // Keep only the low len_q bits of the finished word.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (CNT_W'(i) < len_q) len_mask[i] = 1'b1;
      end
   end

   // Receive FSM: next state, framing registers and output pulses.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      smp_d     = smp_q;
      smp_vld_d = smp_vld_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      bit_ld_d  = 1'b0;
      start_d   = 1'b0;
      stop_d    = 1'b0;
      err_d     = 1'b0;

      if (!rd_en) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         shreg_d   = '0;
         smp_vld_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_ARMED;
            end
            ST_ARMED, ST_SHIFT: begin
               if (cond_start || cond_stop) begin
                  // A condition between words is legal; inside a word it
                  // aborts the word. Either way framing restarts.
                  start_d   = cond_start;
                  stop_d    = cond_stop;
                  err_d     = (state_q == ST_SHIFT);
                  state_d   = ST_ARMED;
                  bit_cnt_d = '0;
                  shreg_d   = '0;
                  smp_vld_d = 1'b0;
               end else if (scl_rise) begin
                  smp_d     = sda_f;
                  smp_vld_d = 1'b1;
                  if (state_q == ST_ARMED) len_d = len_eff;
               end else if (scl_fall && smp_vld_q) begin
                  // Only a fall that closes a sampled high phase moves a bit;
                  // the fall right after START has nothing to shift.
                  shreg_d   = shreg_shift;
                  bit_cnt_d = bit_cnt_inc;
                  bit_ld_d  = 1'b1;
                  smp_vld_d = 1'b0;
                  state_d   = (bit_cnt_inc == len_q) ? ST_DONE : ST_SHIFT;
               end
            end
            ST_DONE: begin
               data_d    = shreg_q & len_mask;
               valid_d   = 1'b1;
               shreg_d   = '0;
               bit_cnt_d = '0;
               smp_vld_d = 1'b0;
               state_d   = ST_ARMED;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Edge history, FSM state, framing registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= ST_IDLE;
         len_q      <= DW_CNT;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         smp_q      <= 1'b0;
         smp_vld_q  <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         bit_ld_q   <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         scl_prev_q <= scl_f;
         sda_prev_q <= sda_f;
         state_q    <= state_d;
         len_q      <= len_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         smp_q      <= smp_d;
         smp_vld_q  <= smp_vld_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         bit_ld_q   <= bit_ld_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_i2c_slave_rx_word.sv
// Bench: two receivers (8-bit and 16-bit words) share one bus. A bit/word
// level model turns every bus action into the ordered list of pulses each
// receiver must emit; a negedge monitor compares every pulse cycle and
// data_o on every cycle. Literal checks pin the model at key points.
module tb_i2c_slave_rx_word;

   localparam int T = 10;

   typedef struct packed {
      logic        s;
      logic        p;
      logic        e;
      logic        l;
      logic        v;
      logic [15:0] d;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0;
   logic        scl = 1'b1;
   logic        sda = 1'b1;
   logic [3:0]  rd_len8 = 4'd0;
   logic [4:0]  rd_len16 = 5'd0;

   logic [7:0]  data8;
   logic [15:0] data16;
   logic        dv8, bl8, busy8, gs8, gp8, er8;
   logic        dv16, bl16, busy16, gs16, gp16, er16;

   ev_t         q0[$];
   ev_t         q1[$];
   logic [15:0] m_last[2];
   logic [15:0] m_word[2];
   int          m_cnt[2];
   int          m_len[2];
   bit          m_en;
   bit          bus_hi;

   int n_gs[2], n_gp[2], n_er[2], n_bl[2], n_dv[2];
   int n_cmp = 0;
   int n_bad = 0;

   ev_t g0, g1;

   i2c_slave_rx_word #(.DATA_WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(3)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_len(rd_len8),
      .data_o(data8), .data_valid(dv8), .bit_ld(bl8), .rd_busy(busy8),
      .get_start(gs8), .get_stop(gp8), .rd_err(er8),
      .scl_i(scl), .sda_i(sda)
   );

   i2c_slave_rx_word #(.DATA_WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(3)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_len(rd_len16),
      .data_o(data16), .data_valid(dv16), .bit_ld(bl16), .rd_busy(busy16),
      .get_start(gs16), .get_stop(gp16), .rd_err(er16),
      .scl_i(scl), .sda_i(sda)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   function automatic int eff_len(input int r, input int dw);
      return (r == 0 || r > dw) ? dw : r;
   endfunction

   function automatic void push(input int i, input ev_t e);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   function automatic void m_bit(input logic b);
      ev_t e;
      for (int i = 0; i < 2; i++) begin
         if (m_en) begin
            if (m_cnt[i] == 0)
               m_len[i] = eff_len((i == 0) ? int'(rd_len8) : int'(rd_len16), (i == 0) ? 8 : 16);
            m_word[i] = m_word[i] * 16'd2 + {15'd0, b};
            m_cnt[i]++;
            e = '0;
            e.l = 1'b1;
            push(i, e);
            if (m_cnt[i] == m_len[i]) begin
               e = '0;
               e.v = 1'b1;
               e.d = m_word[i];
               push(i, e);
               m_word[i] = '0;
               m_cnt[i]  = 0;
            end
         end
      end
   endfunction

   function automatic void m_cond(input bit is_start);
      ev_t e;
      for (int i = 0; i < 2; i++) begin
         if (m_en) begin
            e = '0;
            e.s = is_start;
            e.p = !is_start;
            e.e = (m_cnt[i] > 0);
            push(i, e);
            m_word[i] = '0;
            m_cnt[i]  = 0;
         end
      end
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 2; i++) begin
         m_word[i] = '0;
         m_cnt[i]  = 0;
      end
   endfunction

   // ---------------- monitor ----------------
   task automatic mon(input int i, input ev_t got, input logic [15:0] dat);
      ev_t e;
      int  qs;
      if (got.s | got.p | got.e | got.l | got.v) begin
         n_cmp++;
         qs = (i == 0) ? q0.size() : q1.size();
         if (qs == 0) begin
            n_bad++;
            $display("FAIL dut%0d pulses: got s%0b p%0b e%0b l%0b v%0b expected none",
                     i, got.s, got.p, got.e, got.l, got.v);
         end else begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if ({got.s, got.p, got.e, got.l, got.v} !== {e.s, e.p, e.e, e.l, e.v}) begin
               n_bad++;
               $display("FAIL dut%0d pulses: got s%0b p%0b e%0b l%0b v%0b expected s%0b p%0b e%0b l%0b v%0b",
                        i, got.s, got.p, got.e, got.l, got.v, e.s, e.p, e.e, e.l, e.v);
            end
            if (e.v) m_last[i] = e.d;
         end
      end
      chk($sformatf("dut%0d data_o", i), 32'(dat), 32'(m_last[i]));
   endtask

   always @(negedge clk) begin
      g0 = '0;
      g0.s = gs8; g0.p = gp8; g0.e = er8; g0.l = bl8; g0.v = dv8;
      g1 = '0;
      g1.s = gs16; g1.p = gp16; g1.e = er16; g1.l = bl16; g1.v = dv16;
      n_gs[0] += int'(gs8);  n_gp[0] += int'(gp8);  n_er[0] += int'(er8);
      n_bl[0] += int'(bl8);  n_dv[0] += int'(dv8);
      n_gs[1] += int'(gs16); n_gp[1] += int'(gp16); n_er[1] += int'(er16);
      n_bl[1] += int'(bl16); n_dv[1] += int'(dv16);
      mon(0, g0, {8'h00, data8});
      mon(1, g1, data16);
   end

   // ---------------- bus stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // g > 0 inserts a g-cycle low pulse on SCL inside the high phase.
   task automatic send_bit(input logic b, input int g);
      m_bit(b);
      if (g >= 3) m_bit(b);
      sda = b;
      tick(T);
      scl = 1'b1;
      tick(T);
      if (g > 0) begin
         scl = 1'b0;
         tick(g);
         scl = 1'b1;
         tick(T);
      end
      tick(T);
      scl = 1'b0;
      tick(T);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int k = 7; k >= 0; k--) send_bit(v[k], 0);
   endtask

   task automatic bus_start();
      m_cond(1'b1);
      if (bus_hi) begin
         sda = 1'b0;
         tick(T);
         scl = 1'b0;
         tick(T);
      end else begin
         sda = 1'b1;
         tick(T);
         scl = 1'b1;
         tick(T);
         sda = 1'b0;
         tick(T);
         scl = 1'b0;
         tick(T);
      end
      bus_hi = 1'b0;
   endtask

   task automatic bus_stop();
      m_cond(1'b0);
      sda = 1'b0;
      tick(T);
      scl = 1'b1;
      tick(T);
      sda = 1'b1;
      tick(T);
      bus_hi = 1'b1;
   endtask

   initial begin
      m_en = 1'b0;
      bus_hi = 1'b1;
      m_clear();
      for (int i = 0; i < 2; i++) begin
         m_last[i] = '0;
         m_len[i] = 0;
         n_gs[i] = 0; n_gp[i] = 0; n_er[i] = 0; n_bl[i] = 0; n_dv[i] = 0;
      end

      // reset state
      tick(3);
      rst_n = 1'b1;
      tick(10);
      chk("reset data8", 32'(data8), 32'h0);
      chk("reset data16", 32'(data16), 32'h0);
      chk("reset busy", 32'({busy8, busy16}), 32'h0);

      // A5 with rd_len=0 on the 8-bit receiver, 8 on the 16-bit one
      rd_en = 1'b1;
      m_en = 1'b1;
      rd_len8 = 4'd0;
      rd_len16 = 5'd8;
      tick(5);
      bus_start();
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      chk("busy mid word", 32'({busy8, busy16}), 32'h3);
      send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      chk("A5 data8", 32'(data8), 32'hA5);
      chk("A5 data16", 32'(data16), 32'h00A5);
      chk("A5 starts", 32'(n_gs[0]), 32'd1);
      chk("A5 bit_ld", 32'(n_bl[0]), 32'd8);
      chk("A5 valids", 32'(n_dv[0]), 32'd1);
      chk("A5 busy after", 32'({busy8, busy16}), 32'h0);

      // 9-bit word, then 1-bit word, on the 16-bit receiver
      rd_len16 = 5'd9;
      send_bit(1'b1, 0);
      for (int k = 0; k < 7; k++) send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      chk("9bit data16", 32'(data16), 32'h0101);
      chk("9bit data8", 32'(data8), 32'h80);
      rd_len16 = 5'd1;
      send_bit(1'b0, 0);
      chk("1bit data16", 32'(data16), 32'h0000);
      chk("1bit valids16", 32'(n_dv[1]), 32'd3);
      // 8-bit receiver holds 2 bits of a word here: STOP is an error for it only
      bus_stop();
      chk("stop err8", 32'(n_er[0]), 32'd1);
      chk("stop err16", 32'(n_er[1]), 32'd0);

      // glitch filtering, repeated START between words, STOP
      rd_len16 = 5'd8;
      bus_start();
      send_bit(1'b1, 0); send_bit(1'b1, 2); send_bit(1'b0, 3);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      chk("glitch data8", 32'(data8), 32'hC9);
      bus_start();
      send_byte(8'h5A);
      bus_stop();
      chk("rs data16", 32'(data16), 32'h005A);
      chk("rs err8", 32'(n_er[0]), 32'd1);

      // START inside a word aborts it, next byte is clean
      bus_start();
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
      bus_start();
      chk("abort err8", 32'(n_er[0]), 32'd2);
      chk("abort err16", 32'(n_er[1]), 32'd1);
      send_byte(8'h96);
      bus_stop();
      chk("after abort data8", 32'(data8), 32'h96);

      // rd_en dropped after 3 bits
      bus_start();
      send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      rd_en = 1'b0;
      m_en = 1'b0;
      m_clear();
      tick(3);
      chk("disabled busy", 32'({busy8, busy16}), 32'h0);
      for (int k = 0; k < 5; k++) send_bit(1'b1, 0);
      bus_stop();
      chk("disabled valids8", 32'(n_dv[0]), 32'd5);
      rd_en = 1'b1;
      m_en = 1'b1;
      tick(3);
      bus_start();
      send_byte(8'h3C);
      bus_stop();
      chk("reenable data8", 32'(data8), 32'h3C);

      // async reset in the middle of a word
      bus_start();
      send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      rst_n = 1'b0;
      m_clear();
      q0.delete();
      q1.delete();
      m_last[0] = '0;
      m_last[1] = '0;
      tick(3);
      chk("in reset data8", 32'(data8), 32'h0);
      chk("in reset busy", 32'({busy8, busy16}), 32'h0);
      rst_n = 1'b1;
      tick(20);
      bus_stop();
      bus_start();
      send_byte(8'h3C);
      bus_stop();
      chk("post reset data8", 32'(data8), 32'h3C);
      chk("post reset data16", 32'(data16), 32'h003C);

      tick(30);
      chk("total valids8", 32'(n_dv[0]), 32'd7);
      chk("total valids16", 32'(n_dv[1]), 32'd8);
      chk("total starts", 32'(n_gs[0]), 32'd9);
      chk("total stops", 32'(n_gp[1]), 32'd6);
      chk("dut0 pending", 32'(q0.size()), 32'd0);
      chk("dut1 pending", 32'(q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
